// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the memory-side bus responder: word width, idle bus value,
// scrub/run state encoding and a small address helper.
package bus_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] BUS_Z = {WORD_W{1'bz}};

  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// DEPTH x 32-bit storage with an asynchronous read port and a synchronous write port.
// No reset: contents survive rst and are only cleared by an explicit scrub.
module bus_mem_array
  import bus_mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic [AW-1:0]     ra,
  output logic [WORD_W-1:0] rd,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [WORD_W-1:0] wd
);

  logic [WORD_W-1:0] mem_r [DEPTH];

  assign rd = mem_r[ra];

  // synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wa] <= wd;
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory target on the shared CPU bus: zero-latency word reads, edge-committed writes,
// sticky fault capture, access counters and an optional post-reset scrub.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int          DEPTH        = 1024,
  parameter int          AW           = 10,
  parameter logic [31:0] BASE         = 32'h0000_0000,
  parameter bit          CLEAR_ON_RST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] BUS,
  input  logic        Memread,
  input  logic        Memwrite,
  input  logic [31:0] Addr,
  output logic        ready,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam logic [31:0]   SPAN    = 32'(DEPTH * 4);
  localparam logic [AW-1:0] SC_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] SC_ONE  = AW'(1);

  state_e            state_r, state_nx_s;
  logic [AW-1:0]     sc_r, sc_nx_s;
  logic              ready_r, ready_nx_s;
  logic              err_r;
  logic [31:0]       err_addr_r;
  logic [15:0]       rd_cnt_r, wr_cnt_r;

  logic [31:0]       off_s;
  logic [AW-1:0]     idx_s;
  logic              inrange_s, aligned_s, valid_s;
  logic              rd_ok_s, wr_ok_s, fault_s;
  logic              we_s;
  logic [AW-1:0]     wa_s;
  logic [WORD_W-1:0] wd_s, rd_data_s;

  // Offset wraps modulo 2^32, so addresses below BASE land far out of range.
  assign off_s     = Addr - BASE;
  assign inrange_s = (off_s < SPAN);
  assign aligned_s = word_aligned(Addr[1:0]);
  assign idx_s     = off_s[AW+1:2];
  assign valid_s   = ready_r & inrange_s & aligned_s & ~(Memread & Memwrite);
  assign rd_ok_s   = Memread & ~Memwrite & valid_s;
  assign wr_ok_s   = Memwrite & ~Memread & valid_s;
  assign fault_s   = (Memread | Memwrite) & ~valid_s;

  assign BUS = rd_ok_s ? rd_data_s : BUS_Z;

  assign ready    = ready_r;
  assign err      = err_r;
  assign err_addr = err_addr_r;
  assign rd_cnt   = rd_cnt_r;
  assign wr_cnt   = wr_cnt_r;

  // scrub/run next-state logic
  always_comb begin
    state_nx_s = state_r;
    sc_nx_s    = sc_r;
    ready_nx_s = ready_r;
    case (state_r)
      ST_SCRUB: begin
        sc_nx_s = sc_r + SC_ONE;
        if (sc_r == SC_LAST) begin
          state_nx_s = ST_RUN;
          ready_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_SCRUB;
          ready_nx_s = 1'b0;
        end
      end
      ST_RUN: begin
        state_nx_s = ST_RUN;
        ready_nx_s = 1'b1;
      end
      default: begin
        state_nx_s = ST_RUN;
        ready_nx_s = 1'b1;
      end
    endcase
  end

  // state, scrub counter and ready registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR_ON_RST ? ST_SCRUB : ST_RUN;
      sc_r    <= {AW{1'b0}};
      ready_r <= ~CLEAR_ON_RST;
    end else begin
      state_r <= state_nx_s;
      sc_r    <= sc_nx_s;
      ready_r <= ready_nx_s;
    end
  end

  // Write-port mux: the scrub owns the port while it runs (the bus is locked out then).
  always_comb begin
    we_s = 1'b0;
    wa_s = idx_s;
    wd_s = BUS;
    if (rst) begin
      we_s = 1'b0;
    end else if (state_r == ST_SCRUB) begin
      we_s = 1'b1;
      wa_s = sc_r;
      wd_s = {WORD_W{1'b0}};
    end else begin
      we_s = wr_ok_s;
      wa_s = idx_s;
      wd_s = BUS;
    end
  end

  // counters and sticky fault capture; a fault outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_r   <= 16'h0000;
      wr_cnt_r   <= 16'h0000;
      err_r      <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else begin
      if (rd_ok_s) begin
        rd_cnt_r <= rd_cnt_r + 16'd1;
      end
      if (wr_ok_s) begin
        wr_cnt_r <= wr_cnt_r + 16'd1;
      end
      if (fault_s) begin
        err_r <= 1'b1;
        if (!err_r || err_clr) begin
          err_addr_r <= Addr;
        end
      end else if (err_clr) begin
        err_r      <= 1'b0;
        err_addr_r <= 32'h0000_0000;
      end
    end
  end

  bus_mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk(clk),
    .ra (idx_s),
    .rd (rd_data_s),
    .we (we_s),
    .wa (wa_s),
    .wd (wd_s)
  );

endmodule
